// File: rtl/lab9_soc_usb_rst_seq_if.sv
// Avalon-MM slave bus bundle for the USB reset sequencer.
// The master drives the address and write controls; the slave returns combinational read data.
interface lab9_soc_usb_rst_seq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lab9_soc_usb_rst_seq.sv
// Timed USB host-controller reset sequencer: a programmable low pulse on usb_rst_n,
// then a programmable settle time, then a done flag with an optional level interrupt.
module lab9_soc_usb_rst_seq #(
  parameter logic [15:0] DEFAULT_PULSE  = 16'd1000,
  parameter logic [15:0] DEFAULT_SETTLE = 16'd100
) (
  input  logic                         clk,
  input  logic                         reset_n,
  lab9_soc_usb_rst_seq_if.slave        bus,
  output logic                         usb_rst_n,
  output logic                         usb_ready,
  output logic                         irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PULSE  = 2'd1;
  localparam logic [1:0] ADDR_SETTLE = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pulse_q, pulse_d;
  logic [15:0] settle_q, settle_d;
  logic        done_q, done_d;
  logic        irq_en_q, irq_en_d;
  logic        usb_rst_n_q, usb_rst_n_d;

  logic        wr_s;
  logic        ctrl_wr_s;
  logic        start_s;
  logic        abort_s;
  logic        clr_s;
  logic        busy_s;

  assign wr_s      = bus.chipselect & ~bus.write_n;
  assign ctrl_wr_s = wr_s & (bus.address == ADDR_CTRL);
  assign start_s   = ctrl_wr_s & bus.writedata[0];
  assign abort_s   = ctrl_wr_s & bus.writedata[1];
  assign clr_s     = ctrl_wr_s & bus.writedata[2];
  assign busy_s    = (state_q != ST_IDLE);

  // Sequencer next state; abort beats both start and a same-cycle completion.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clr_s) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_s && !abort_s) begin
          state_d = ST_ASSERT;
          count_d = (pulse_q == 16'd0) ? 16'd0 : (pulse_q - 16'd1);
          done_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          count_d = 16'd0;
        end else if (count_q == 16'd0) begin
          if (settle_q == 16'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            count_d = settle_q - 16'd1;
          end
        end else begin
          count_d = count_q - 16'd1;
        end
      end
      ST_SETTLE: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          count_d = 16'd0;
        end else if (count_q == 16'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          count_d = count_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 16'd0;
      end
    endcase

    // Registered from the next state so the pin moves on the same edge as the FSM.
    usb_rst_n_d = (state_d != ST_ASSERT);
  end

  // Configuration registers; timing values are frozen while a sequence runs.
  always_comb begin
    if (wr_s && (bus.address == ADDR_PULSE) && !busy_s) begin
      pulse_d = bus.writedata[15:0];
    end else begin
      pulse_d = pulse_q;
    end

    if (wr_s && (bus.address == ADDR_SETTLE) && !busy_s) begin
      settle_d = bus.writedata[15:0];
    end else begin
      settle_d = settle_q;
    end

    if (ctrl_wr_s) begin
      irq_en_d = bus.writedata[3];
    end else begin
      irq_en_d = irq_en_q;
    end
  end

  // State and register storage; reset holds the USB chip in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= 16'd0;
      pulse_q     <= DEFAULT_PULSE;
      settle_q    <= DEFAULT_SETTLE;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      usb_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pulse_q     <= pulse_d;
      settle_q    <= settle_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      usb_rst_n_q <= usb_rst_n_d;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    case (bus.address)
      ADDR_CTRL:   bus.readdata = {27'd0, irq_en_q, state_q, done_q, busy_s};
      ADDR_PULSE:  bus.readdata = {16'd0, pulse_q};
      ADDR_SETTLE: bus.readdata = {16'd0, settle_q};
      ADDR_COUNT:  bus.readdata = {16'd0, count_q};
      default:     bus.readdata = 32'd0;
    endcase
  end

  assign usb_rst_n = usb_rst_n_q;
  assign usb_ready = done_q & ~busy_s;
  assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_lab9_soc_usb_rst_seq.sv
// Scoreboard bench for the USB reset sequencer: the driver queues expected values,
// a negedge monitor drains the queue and compares against the DUT outputs.
module tb_lab9_soc_usb_rst_seq;

  localparam int K_RD  = 0;
  localparam int K_RST = 1;
  localparam int K_RDY = 2;
  localparam int K_IRQ = 3;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } item_t;

  logic clk = 1'b0;
  logic reset_n;
  logic usb_rst_n;
  logic usb_ready;
  logic irq;

  item_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lab9_soc_usb_rst_seq_if bus_if ();

  lab9_soc_usb_rst_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
    .usb_rst_n (usb_rst_n),
    .usb_ready (usb_ready),
    .irq       (irq)
  );

  // Monitor: every queued expectation is checked at the next falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t it;
      logic [31:0] act;
      it = sb.pop_front();
      case (it.kind)
        K_RD:    act = bus_if.readdata;
        K_RST:   act = {31'd0, usb_rst_n};
        K_RDY:   act = {31'd0, usb_ready};
        K_IRQ:   act = {31'd0, irq};
        default: act = 32'hxxxx_xxxx;
      endcase
      n_tests++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", it.name, act, it.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    step();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] e);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    sb.push_back('{K_RD, nm, e});
    step();
    bus_if.chipselect = 1'b0;
  endtask

  task automatic sig(input int k, input string nm, input logic e);
    sb.push_back('{k, nm, {31'd0, e}});
  endtask

  initial begin
    logic [31:0] exp_ctrl;
    reset_n           = 1'b0;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;

    // Reset state
    step();
    step();
    sig(K_RST, "rst_held_low", 1'b0);
    step();
    reset_n = 1'b1;
    step();
    step();
    sig(K_RST, "post_rst_usb_rst_n", 1'b1);
    sig(K_RDY, "post_rst_ready", 1'b0);
    sig(K_IRQ, "post_rst_irq", 1'b0);
    rd(2'd1, "post_rst_pulse", 32'd1000);
    rd(2'd2, "post_rst_settle", 32'd100);
    rd(2'd0, "post_rst_ctrl", 32'd0);
    rd(2'd3, "post_rst_count", 32'd0);

    // PULSE=5, SETTLE=3, START+IRQ_EN: 5 low cycles, 8 busy cycles
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 5)      exp_ctrl = 32'h15;
      else if (i <= 8) exp_ctrl = 32'h19;
      else             exp_ctrl = 32'h12;
      sig(K_RST, $sformatf("seq_rst_n_c%0d", i), (i <= 5) ? 1'b0 : 1'b1);
      rd(2'd0, $sformatf("seq_ctrl_c%0d", i), exp_ctrl);
    end
    sig(K_RDY, "seq_ready", 1'b1);
    sig(K_IRQ, "seq_irq", 1'b1);
    rd(2'd3, "seq_count_end", 32'd0);
    wr(2'd0, 32'h4);
    sig(K_IRQ, "clr_irq", 1'b0);
    sig(K_RDY, "clr_ready", 1'b0);
    rd(2'd0, "clr_ctrl", 32'h0);

    // PULSE=0, SETTLE=0: single low cycle, done right after
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h1);
    sig(K_RST, "p0_rst_low", 1'b0);
    rd(2'd0, "p0_ctrl_busy", 32'h05);
    sig(K_RST, "p0_rst_high", 1'b1);
    sig(K_RDY, "p0_ready", 1'b1);
    sig(K_IRQ, "p0_irq_masked", 1'b0);
    rd(2'd0, "p0_ctrl_done", 32'h02);

    // PULSE=50: busy write lock, ignored restart, abort
    wr(2'd1, 32'd50);
    wr(2'd2, 32'd20);
    wr(2'd0, 32'h1);
    rd(2'd0, "ab_ctrl_busy", 32'h05);
    wr(2'd1, 32'd7);
    rd(2'd1, "ab_pulse_locked", 32'd50);
    wr(2'd0, 32'h1);
    rd(2'd3, "ab_count_no_restart", 32'd45);
    repeat (4) step();
    wr(2'd0, 32'h2);
    sig(K_RST, "ab_rst_n", 1'b1);
    sig(K_RDY, "ab_ready", 1'b0);
    rd(2'd0, "ab_ctrl", 32'h0);
    rd(2'd3, "ab_count", 32'd0);

    // START+ABORT together, while busy and while idle
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h3);
    rd(2'd0, "sa_busy_ctrl", 32'h0);
    rd(2'd3, "sa_busy_count", 32'd0);
    wr(2'd0, 32'h3);
    sig(K_RST, "sa_idle_rst_n", 1'b1);
    rd(2'd0, "sa_idle_ctrl", 32'h0);

    // Reset pulsed during SETTLE
    wr(2'd0, 32'h9);
    repeat (54) step();
    rd(2'd0, "rs_in_settle", 32'h19);
    reset_n = 1'b0;
    #1;
    sig(K_RST, "rs_rst_low", 1'b0);
    rd(2'd0, "rs_ctrl_in_reset", 32'h0);
    reset_n = 1'b1;
    step();
    step();
    sig(K_RST, "rs_rst_n", 1'b1);
    sig(K_IRQ, "rs_irq", 1'b0);
    sig(K_RDY, "rs_ready", 1'b0);
    rd(2'd1, "rs_pulse", 32'd1000);
    rd(2'd2, "rs_settle", 32'd100);
    rd(2'd0, "rs_ctrl", 32'h0);

    step();
    step();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lab9_soc_usb_rst_seq.md
# lab9_soc_usb_rst_seq

Avalon-MM slave that replaces the bare USB reset PIO with a timed reset sequencer for the USB host controller. Software writes a start command. The block then drives the USB controller's reset low for a programmable number of clock cycles, holds off for a programmable settle time, and then flags completion, optionally raising an interrupt. It sits in the lab9 SoC on the same Avalon bus as the other PIOs; its `usb_rst_n` output goes directly to the USB chip's reset pin.

## Interface
- `DEFAULT_PULSE`, 16'd1000: reset value of the PULSE register (cycles).
- `DEFAULT_SETTLE`, 16'd100: reset value of the SETTLE register (cycles).
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `address`, in, 2: register select.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: read data. Combinational, zero wait states, unused bits 0.
- `usb_rst_n`, out, 1: active-low reset to the USB controller.
- `usb_ready`, out, 1: high when the sequence has completed and the block is idle.
- `irq`, out, 1: level interrupt.

## Operation
- Registers, indexed by `address`:
  - 0 CTRL. Write bits:
    - bit0 START
    - bit1 ABORT
    - bit2 DONE_CLR (write-1-to-clear)
    - bit3 IRQ_EN (stored)
  - 0 CTRL. Read bits:
    - bit0 busy
    - bit1 done
    - bits3:2 state
    - bit4 irq_en
  - 1 PULSE[15:0], read/write.
  - 2 SETTLE[15:0], read/write.
  - 3 COUNT[15:0], read-only: current down-counter value.
- A write occurs when `chipselect` is high and `write_n` is low.
- Writes to PULSE and SETTLE are ignored while busy. IRQ_EN is always writable.
- FSM states and encodings:
  - IDLE = 0
  - ASSERT = 1
  - SETTLE = 2
- IDLE:
  - START moves to ASSERT.
  - `count` loads `max(PULSE,1) - 1`.
  - done clears.
- ASSERT:
  - `usb_rst_n` = 0.
  - `count` decrements each cycle.
  - At `count` == 0: if SETTLE == 0, go to IDLE and set done. Otherwise go to SETTLE and load `count` = SETTLE - 1.
- SETTLE:
  - `usb_rst_n` = 1.
  - `count` decrements each cycle.
  - At `count` == 0: go to IDLE and set done.
- ABORT, written in ASSERT or SETTLE:
  - Go to IDLE next cycle.
  - `usb_rst_n` = 1.
  - done is not set.
  - `count` = 0.
- Output definitions:
  - busy = (state != IDLE).
  - `usb_ready` = done & ~busy.
  - `irq` = done & irq_en.
- Simultaneous events:
  - START while busy is ignored.
  - START and ABORT in the same write: ABORT wins, so the block stays or becomes IDLE.
  - DONE_CLR together with START: start proceeds and done is 0.
  - A done-set on the same cycle as DONE_CLR: set wins.
- Arithmetic: PULSE = 0 is treated as 1. The counter is 16-bit and never wraps, because it is only decremented when nonzero.

## Timing
- Reset values:
  - state = IDLE
  - `usb_rst_n` = 0 while `reset_n` is low, 1 after reset release
  - done = 0
  - irq_en = 0
  - `irq` = 0
  - `usb_ready` = 0
  - PULSE = `DEFAULT_PULSE`
  - SETTLE = `DEFAULT_SETTLE`
  - `count` = 0
  - `readdata` reflects the registers
- `usb_rst_n` is registered: an asynchronous reset holds the USB chip in reset.
- Latency: START written at edge N gives `usb_rst_n` low from N+1 for exactly P = max(PULSE,1) cycles, so it rises at N+1+P.
- done and `usb_ready` rise at N+1+P+SETTLE and stay high until cleared.
- ABORT written at edge M: `usb_rst_n` is 1 and busy is 0 from M+1.
- Reads have 0-cycle latency and no side effects.
- Asserting `reset_n` mid-sequence returns the block to IDLE immediately. Programmed PULSE and SETTLE revert to their defaults.

## Test plan
- Post-reset reads: PULSE = 1000, SETTLE = 100, CTRL = 0. After reset release, `usb_rst_n` = 1 and `usb_ready` = 0.
- PULSE = 5, SETTLE = 3, write CTRL = 0x9 (START + IRQ_EN):
  - `usb_rst_n` is low for exactly 5 cycles.
  - busy stays high for 8 cycles.
  - Then done = 1, `usb_ready` = 1, `irq` = 1.
  - Writing CTRL = 0x4 clears `irq` and `usb_ready`.
- PULSE = 0, SETTLE = 0, START: `usb_rst_n` low for exactly 1 cycle, done set on the following cycle.
- PULSE = 50, START, ABORT after 10 cycles:
  - `usb_rst_n` returns to 1 the next cycle.
  - busy = 0, done = 0, COUNT = 0.
- While busy:
  - A write of PULSE = 7 is ignored (it still reads 50).
  - A second START does not restart the counter.
  - Writing START + ABORT together leaves the block IDLE.
- `reset_n` pulsed low during SETTLE: state returns to IDLE, PULSE reads back 1000, `irq` = 0.
